// File: rtl/i2s_receiver.sv
// I2S slave receiver: oversamples BCLK/ADCLRC/ADCDAT on clk and emits left/right sample pairs.
// Optional slot-length checking and an err_cnt port are enabled by defining I2S_RX_LEN_CHECK_EN.
module i2s_receiver #(
    parameter int DATA_W  = 24,
    parameter int SYNC_ST = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bclk,
    input  logic              adclrc,
    input  logic              adcdat,
    output logic [DATA_W-1:0] left_data,
    output logic [DATA_W-1:0] right_data,
    output logic              sample_valid,
    output logic              frame_err
`ifdef I2S_RX_LEN_CHECK_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam int            CW   = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    typedef enum logic [1:0] {SYNC, SHIFT, WAIT} state_t;

    logic [1:0] rst_pipe;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset)
        if (!reset) rst_pipe <= '0;
        else        rst_pipe <= {rst_pipe[0], 1'b1};

    assign rst_n = rst_pipe[1];

    logic [SYNC_ST-1:0] bclk_sy, lr_sy, dat_sy;
    logic               bclk_s, lr_s, dat_s;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bclk_sy <= '0;
            lr_sy   <= '0;
            dat_sy  <= '0;
        end else begin
            bclk_sy <= {bclk_sy[SYNC_ST-2:0], bclk};
            lr_sy   <= {lr_sy[SYNC_ST-2:0], adclrc};
            dat_sy  <= {dat_sy[SYNC_ST-2:0], adcdat};
        end

    assign bclk_s = bclk_sy[SYNC_ST-1];
    assign lr_s   = lr_sy[SYNC_ST-1];
    assign dat_s  = dat_sy[SYNC_ST-1];

    state_t            state;
    logic              bclk_d, lr_prev, lr_seen, chan, done, done_ch;
    logic              rise, lr_edge, short_evt, err_evt;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sr, sr_next, word, hold;

    assign rise      = bclk_s & ~bclk_d;
    // lr_seen blocks a false edge against the reset value of lr_prev
    assign lr_edge   = rise & lr_seen & (lr_s ^ lr_prev);
    assign sr_next   = {sr[DATA_W-2:0], dat_s};
    assign short_evt = lr_edge & (state == SHIFT) & (cnt != LAST);

    // The rise that first sees the new LR level carries the previous slot's LSB,
    // so it doubles as the I2S one-bit delay and shifting starts on the next rise.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= SYNC;
            bclk_d  <= 1'b0;
            lr_prev <= 1'b0;
            lr_seen <= 1'b0;
            chan    <= 1'b0;
            cnt     <= '0;
            sr      <= '0;
            word    <= '0;
            done    <= 1'b0;
            done_ch <= 1'b0;
        end else begin
            bclk_d <= bclk_s;
            done   <= 1'b0;
            if (rise) begin
                lr_prev <= lr_s;
                lr_seen <= 1'b1;
                case (state)
                    SYNC, WAIT:
                        if (lr_edge) begin
                            state <= SHIFT;
                            cnt   <= '0;
                            sr    <= '0;
                            chan  <= lr_s;
                        end
                    SHIFT:
                        if (lr_edge) begin
                            // edge bit is this slot's last bit; a short word is MSB-aligned
                            done    <= 1'b1;
                            done_ch <= chan;
                            word    <= sr_next << (LAST - cnt);
                            cnt     <= '0;
                            sr      <= '0;
                            chan    <= lr_s;
                        end else begin
                            sr  <= sr_next;
                            cnt <= cnt + 1'b1;
                            if (cnt == LAST) begin
                                done    <= 1'b1;
                                done_ch <= chan;
                                word    <= sr_next;
                                state   <= WAIT;
                            end
                        end
                    default: state <= SYNC;
                endcase
            end
        end

`ifdef I2S_RX_LEN_CHECK_EN
    logic [5:0] slot_cnt;
    logic       len_evt;

    // counts rises after the delay bit; the closing edge rise makes it slot length
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            slot_cnt <= '0;
        else if (rise) begin
            if (lr_edge)
                slot_cnt <= '0;
            else if (state != SYNC && slot_cnt != 6'h3F)
                slot_cnt <= slot_cnt + 6'd1;
        end

    assign len_evt = lr_edge & (state != SYNC) & (slot_cnt != 6'd31);
    assign err_evt = short_evt | len_evt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            err_cnt <= '0;
        else if (err_evt && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
`else
    assign err_evt = short_evt;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hold         <= '0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            if (err_evt)
                frame_err <= 1'b1;
            if (done) begin
                if (done_ch) begin
                    left_data    <= hold;
                    right_data   <= word;
                    sample_valid <= 1'b1;
                end else begin
                    hold <= word;
                end
            end
        end

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: a behavioural I2S codec drives table-driven frames,
// a monitor collects strobed pairs, and hand sequences cover sync, reset and slot-length cases.
module tb_i2s_receiver;

    logic        clk = 1'b0, reset = 1'b0, bclk = 1'b0, adclrc = 1'b0, adcdat = 1'b0;
    logic [23:0] left_data, right_data;
    logic        sample_valid, frame_err;
`ifdef I2S_RX_LEN_CHECK_EN
    logic [7:0]  err_cnt;
`endif

    i2s_receiver dut (
        .clk          (clk),
        .reset        (reset),
        .bclk         (bclk),
        .adclrc       (adclrc),
        .adcdat       (adcdat),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .frame_err    (frame_err)
`ifdef I2S_RX_LEN_CHECK_EN
        ,
        .err_cnt      (err_cnt)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [23:0] el;
        logic [23:0] er;
        logic        ee;
    } pair_t;

    typedef struct {
        logic [23:0] ls;
        logic [7:0]  lp;
        int          ln;
        logic [23:0] rs;
        logic [7:0]  rp;
        int          rn;
        logic [23:0] el;
        logic [23:0] er;
        logic        ee;
    } vec_t;

    int    cyc = 0;
    int    checks = 0, errors = 0;
    int    rst_bit = -1;
    logic  rst_to = 1'b1;
    logic  last_bit = 1'b0;
    logic  prev_v = 1'b0;
    pair_t pair_q[$];
    int    vcyc_q[$];
    int    lsb_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (sample_valid) begin
            pair_t p;
            checks++;
            if (prev_v) begin
                errors++;
                $display("FAIL valid_width got=2 consecutive cycles want=1 at cyc %0d", cyc);
            end
            p.el = left_data;
            p.er = right_data;
            p.ee = frame_err;
            pair_q.push_back(p);
            vcyc_q.push_back(cyc);
        end
        prev_v = sample_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // One I2S slot of n bits; data lags LR by one bit, so bit 0 carries the previous slot's last bit.
    task automatic send_slot(input logic lr, input logic [23:0] smp, input logic [7:0] pad, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == rst_bit) reset = rst_to;
            bclk   = 1'b0;
            adclrc = lr;
            adcdat = last_bit;
            #40;
            bclk = 1'b1;
            if (lr && i == 24) lsb_q.push_back(cyc);
            #40;
            last_bit = (i < 24) ? smp[23-i] : (i < 32) ? pad[31-i] : 1'b0;
        end
    endtask

    initial begin
        vec_t vt[6];
        vt[0] = '{24'hA5A5A5, 8'h00, 32, 24'h5A5A5A, 8'h00, 32, 24'hA5A5A5, 24'h5A5A5A, 1'b0};
        vt[1] = '{24'h800000, 8'h00, 32, 24'h7FFFFF, 8'hFF, 32, 24'h800000, 24'h7FFFFF, 1'b0};
        vt[2] = '{24'h123456, 8'hFF, 32, 24'hBEEF00, 8'h00, 16, 24'h123456, 24'hBEEF00, 1'b1};
        vt[3] = '{24'hA5A5A5, 8'h00, 32, 24'h5A5A5A, 8'h00, 32, 24'hA5A5A5, 24'h5A5A5A, 1'b1};
        vt[4] = '{24'h000001, 8'hAA, 32, 24'hFFFFFE, 8'h55, 32, 24'h000001, 24'hFFFFFE, 1'b1};
        vt[5] = '{24'h111111, 8'h00, 32, 24'h222222, 8'h00, 32, 24'h111111, 24'h222222, 1'b1};

        @(posedge clk);
        #7;
        // traffic while held in reset
        send_slot(1'b0, 24'hA5A5A5, 8'h00, 32);
        send_slot(1'b1, 24'h5A5A5A, 8'h00, 32);
        send_slot(1'b0, 24'h123456, 8'h00, 32);
        chk("rst_left", 32'(left_data), 32'h0);
        chk("rst_right", 32'(right_data), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_strobes", pair_q.size(), 0);

        // release part-way through a right slot; that partial pair must not appear
        rst_bit = 10;
        rst_to  = 1'b1;
        send_slot(1'b1, 24'h5A5A5A, 8'h00, 32);
        rst_bit = -1;
        lsb_q.delete();

        for (int i = 0; i < 6; i++) begin
            send_slot(1'b0, vt[i].ls, vt[i].lp, vt[i].ln);
            send_slot(1'b1, vt[i].rs, vt[i].rp, vt[i].rn);
        end

        chk("strobe_count", pair_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < pair_q.size()) begin
                chk($sformatf("v%0d_left", i), 32'(pair_q[i].el), 32'(vt[i].el));
                chk($sformatf("v%0d_right", i), 32'(pair_q[i].er), 32'(vt[i].er));
                chk($sformatf("v%0d_frame_err", i), 32'(pair_q[i].ee), 32'(vt[i].ee));
            end
        end
        if (vcyc_q.size() >= 2 && lsb_q.size() >= 1) begin
            chk("latency", vcyc_q[0] - lsb_q[0], 4);
            chk("cadence", vcyc_q[1] - vcyc_q[0], 256);
        end

        // reset asserted mid right word: no strobe, everything cleared
        send_slot(1'b0, 24'h333333, 8'h00, 32);
        rst_bit = 10;
        rst_to  = 1'b0;
        send_slot(1'b1, 24'h444444, 8'h00, 32);
        rst_bit = -1;
        chk("midrst_strobes", pair_q.size(), 6);
        chk("midrst_left", 32'(left_data), 32'h0);
        chk("midrst_right", 32'(right_data), 32'h0);
        chk("midrst_frame_err", 32'(frame_err), 32'h0);

        // resync, then a 33-bit right slot
        reset = 1'b1;
        send_slot(1'b1, 24'h000000, 8'h00, 32);
        send_slot(1'b0, 24'h555555, 8'h00, 32);
        send_slot(1'b1, 24'h666666, 8'h00, 33);
        send_slot(1'b0, 24'h777777, 8'h00, 32);
        chk("long_strobes", pair_q.size(), 7);
        if (pair_q.size() > 6) begin
            chk("long_left", 32'(pair_q[6].el), 32'h555555);
            chk("long_right", 32'(pair_q[6].er), 32'h666666);
        end
`ifdef I2S_RX_LEN_CHECK_EN
        chk("long_frame_err", 32'(frame_err), 32'h1);
        chk("long_err_cnt", 32'(err_cnt), 32'd1);
        for (int k = 0; k < 301; k++)
            send_slot((k % 2 == 0) ? 1'b1 : 1'b0, 24'hFFFFFF, 8'h00, 8);
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);
        chk("sat_frame_err", 32'(frame_err), 32'h1);
`else
        chk("long_frame_err", 32'(frame_err), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
